// File: rtl/zero_io_pkg.sv
// Shared types and constants for the Zero machine I/O channel subsystem.
package zero_io_pkg;

    // CPU-side operation codes carried on cpu_op
    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_IN     = 2'd1,
        OP_INSIZE = 2'd2,
        OP_OUT    = 2'd3
    } opKind_e;

    // CPU op sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } ioState_e;

    // Values for the BLOCKING parameter
    localparam int unsigned BLOCK_STALL = 1;
    localparam int unsigned BLOCK_DROP  = 0;

    // Channel-select width; a single channel still needs one select bit
    function automatic int unsigned chanWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zero_io_fifo.sv
// Single-clock FIFO with same-cycle push+pop (also at full) and occupancy count.
module zero_io_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             empty;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CNTW'(DEPTH));
    // A pop on empty is ignored; a push at full only lands when a pop frees the slot
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap mod DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/zero_io_channels.sv
// Multi-channel I/O for the Zero machine: serves in, inSize and out via per-channel FIFOs.
module zero_io_channels
    import zero_io_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned NCH      = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BLOCKING = BLOCK_STALL,
    localparam int unsigned CW      = chanWidth(NCH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             cpu_op,
    input  logic [CW-1:0]          cpu_chan,
    input  logic [WIDTH-1:0]       cpu_wdata,
    output logic                   cpu_done,
    output logic [WIDTH-1:0]       cpu_rdata,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic [NCH-1:0]         out_valid,
    output logic [NCH*WIDTH-1:0]   out_data,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH-1:0]         overflow,
    output logic [NCH-1:0]         underflow,
    output logic                   bad_chan
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    ioState_e         state;
    ioState_e         stateNext;
    opKind_e          op;
    logic             chanOk;
    logic             canRetire;
    logic             fire;

    logic [CNTW-1:0]  inCount  [NCH];
    logic [CNTW-1:0]  outCount [NCH];
    logic [WIDTH-1:0] inHead   [NCH];
    logic [NCH-1:0]   inEmpty;
    logic [NCH-1:0]   inFull;
    logic [NCH-1:0]   outFull;
    logic [NCH-1:0]   extInPush;
    logic [NCH-1:0]   extOutPop;
    logic [NCH-1:0]   inPop;
    logic [NCH-1:0]   outPush;
    logic [NCH-1:0]   outPop;
    logic [NCH-1:0]   dropOldest;
    logic [NCH-1:0]   underSet;
    logic             badSet;
    logic [WIDTH-1:0] rdataNext;

    logic [NCH-1:0]   selMask;
    logic             selInEmpty;
    logic [WIDTH-1:0] selInHead;
    logic [CNTW-1:0]  selInCount;
    logic             selOutFull;

    assign op     = opKind_e'(cpu_op);
    assign chanOk = (32'(cpu_chan) < NCH);

    // Per-channel input and output FIFOs plus their external handshakes
    for (genvar c = 0; c < NCH; c++) begin : gChan
        zero_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uInFifo (
            .clock    (clock),
            .reset    (reset),
            .push     (extInPush[c]),
            .pushData (in_data[c*WIDTH +: WIDTH]),
            .pop      (inPop[c]),
            .head     (inHead[c]),
            .count    (inCount[c]),
            .full     (inFull[c])
        );

        zero_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uOutFifo (
            .clock    (clock),
            .reset    (reset),
            .push     (outPush[c]),
            .pushData (cpu_wdata),
            .pop      (outPop[c]),
            .head     (out_data[c*WIDTH +: WIDTH]),
            .count    (outCount[c]),
            .full     (outFull[c])
        );

        assign inEmpty[c]   = (inCount[c] == '0);
        assign in_ready[c]  = !inFull[c];
        assign out_valid[c] = (outCount[c] != '0);
        assign extInPush[c] = in_valid[c] && in_ready[c];
        assign extOutPop[c] = out_valid[c] && out_ready[c];
    end

    // Channel mux: status of the channel named by cpu_chan (neutral when out of range)
    always_comb begin
        selMask    = '0;
        selInEmpty = 1'b1;
        selInHead  = '0;
        selInCount = '0;
        selOutFull = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (chanOk && cpu_chan == CW'(c)) begin
                selMask[c] = 1'b1;
                selInEmpty = inEmpty[c];
                selInHead  = inHead[c];
                selInCount = inCount[c];
                selOutFull = outFull[c];
            end
        end
    end

    // Whether the pending op can complete this cycle without stalling
    always_comb begin
        canRetire = 1'b0;
        case (op)
            OP_INSIZE: canRetire = 1'b1;
            OP_IN:     canRetire = !chanOk || !selInEmpty || (BLOCKING == BLOCK_DROP);
            OP_OUT:    canRetire = !chanOk || !selOutFull || (BLOCKING == BLOCK_DROP);
            default:   canRetire = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // FSM next state; EXEC always returns to IDLE so a held op is not re-run
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (op != OP_NONE) stateNext = canRetire ? EXEC : WAIT;
            end
            WAIT: begin
                if (op == OP_NONE)  stateNext = IDLE;
                else if (canRetire) stateNext = EXEC;
            end
            EXEC:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs: FIFO side effects and result value on the retiring edge
    always_comb begin
        fire       = (state == IDLE || state == WAIT) && (op != OP_NONE) && canRetire;
        inPop      = '0;
        outPush    = '0;
        dropOldest = '0;
        underSet   = '0;
        badSet     = 1'b0;
        rdataNext  = '0;
        if (fire) begin
            if (!chanOk) begin
                badSet = 1'b1;
            end else begin
                case (op)
                    OP_IN: begin
                        inPop     = selMask & ~inEmpty;
                        underSet  = selMask & inEmpty;
                        rdataNext = selInEmpty ? '0 : selInHead;
                    end
                    OP_INSIZE: rdataNext = WIDTH'(selInCount);
                    OP_OUT: begin
                        outPush    = selMask;
                        // Full with no consumer pop: evict the oldest word to make room
                        dropOldest = selMask & outFull & ~extOutPop;
                    end
                    default: rdataNext = '0;
                endcase
            end
        end
        outPop = extOutPop | dropOldest;
    end

    // Registered CPU results and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            overflow  <= '0;
            underflow <= '0;
            bad_chan  <= 1'b0;
        end else begin
            cpu_done  <= fire;
            if (fire) cpu_rdata <= rdataNext;
            overflow  <= overflow | dropOldest;
            underflow <= underflow | underSet;
            bad_chan  <= bad_chan | badSet;
        end
    end

endmodule

// File: tb/tb_zero_io_channels.sv
// Directed bench: blocking instance A (NCH=2, DEPTH=8) and non-blocking instance B (NCH=3, DEPTH=4).
module tb_zero_io_channels;
    import zero_io_pkg::*;

    localparam int unsigned W = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A signals
    logic [1:0]   aOp;
    logic [0:0]   aChan;
    logic [W-1:0] aWdata;
    logic         aDone;
    logic [W-1:0] aRdata;
    logic [1:0]   aInValid;
    logic [2*W-1:0] aInData;
    logic [1:0]   aInReady;
    logic [1:0]   aOutValid;
    logic [2*W-1:0] aOutData;
    logic [1:0]   aOutReady;
    logic [1:0]   aOverflow;
    logic [1:0]   aUnderflow;
    logic         aBad;

    // Instance B signals
    logic [1:0]   bOp;
    logic [1:0]   bChan;
    logic [W-1:0] bWdata;
    logic         bDone;
    logic [W-1:0] bRdata;
    logic [2:0]   bInValid;
    logic [3*W-1:0] bInData;
    logic [2:0]   bInReady;
    logic [2:0]   bOutValid;
    logic [3*W-1:0] bOutData;
    logic [2:0]   bOutReady;
    logic [2:0]   bOverflow;
    logic [2:0]   bUnderflow;
    logic         bBad;

    zero_io_channels #(.WIDTH(W), .NCH(2), .DEPTH(8), .BLOCKING(1)) dutA (
        .clock(clock), .reset(reset),
        .cpu_op(aOp), .cpu_chan(aChan), .cpu_wdata(aWdata),
        .cpu_done(aDone), .cpu_rdata(aRdata),
        .in_valid(aInValid), .in_data(aInData), .in_ready(aInReady),
        .out_valid(aOutValid), .out_data(aOutData), .out_ready(aOutReady),
        .overflow(aOverflow), .underflow(aUnderflow), .bad_chan(aBad)
    );

    zero_io_channels #(.WIDTH(W), .NCH(3), .DEPTH(4), .BLOCKING(0)) dutB (
        .clock(clock), .reset(reset),
        .cpu_op(bOp), .cpu_chan(bChan), .cpu_wdata(bWdata),
        .cpu_done(bDone), .cpu_rdata(bRdata),
        .in_valid(bInValid), .in_data(bInData), .in_ready(bInReady),
        .out_valid(bOutValid), .out_data(bOutData), .out_ready(bOutReady),
        .overflow(bOverflow), .underflow(bUnderflow), .bad_chan(bBad)
    );

    int nChecks = 0;
    int nBad    = 0;

    logic [W-1:0] aOutQ[$];
    logic [W-1:0] bOutQ0[$];
    logic [W-1:0] bOutQ1[$];

    // Record consumer-side transfers; ready only changes just after a rising edge
    always @(negedge clock) begin
        if (!reset) begin
            if (aOutValid[0] && aOutReady[0]) aOutQ.push_back(aOutData[W-1:0]);
            if (bOutValid[0] && bOutReady[0]) bOutQ0.push_back(bOutData[W-1:0]);
            if (bOutValid[1] && bOutReady[1]) bOutQ1.push_back(bOutData[2*W-1:W]);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one CPU op, wait (bounded) for cpu_done, then drop the op and idle one cycle
    task automatic cpuOp(input bit onB, input logic [1:0] op, input int chan,
                         input logic [W-1:0] wdata, output logic [W-1:0] rdata, output int lat);
        bit seen;
        seen  = 1'b0;
        rdata = '0;
        lat   = 0;
        if (onB) begin bOp = op; bChan = 2'(chan); bWdata = wdata; end
        else     begin aOp = op; aChan = 1'(chan); aWdata = wdata; end
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (onB ? bDone : aDone) begin
                seen  = 1'b1;
                lat   = i;
                rdata = onB ? bRdata : aRdata;
            end
        end
        aOp = OP_NONE;
        bOp = OP_NONE;
        if (!seen) checkVal("cpu_done timeout", 32'd0, 32'd1);
        tick();
        checkVal("cpu_done single pulse", 32'(onB ? bDone : aDone), 32'd0);
    endtask

    task automatic extPush(input bit onB, input int chan, input logic [W-1:0] data);
        if (onB) begin bInValid[chan] = 1'b1; bInData[chan*W +: W] = data; end
        else     begin aInValid[chan] = 1'b1; aInData[chan*W +: W] = data; end
        tick();
        if (onB) bInValid[chan] = 1'b0;
        else     aInValid[chan] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic [W-1:0] got;
        int lat;
        int maxLat;
        int doneCnt;
        int forInExp[9];
        forInExp = '{1, 2, 3, 3, 33, 2, 22, 1, 11};

        aOp = OP_NONE; aChan = '0; aWdata = '0; aInValid = '0; aInData = '0; aOutReady = '0;
        bOp = OP_NONE; bChan = '0; bWdata = '0; bInValid = '0; bInData = '0; bOutReady = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        checkVal("reset cpu_done", 32'(aDone), 32'd0);
        checkVal("reset cpu_rdata", 32'(aRdata), 32'd0);
        checkVal("reset A in_ready", 32'(aInReady), 32'd3);
        checkVal("reset A out_valid", 32'(aOutValid), 32'd0);
        checkVal("reset A flags", 32'({aOverflow, aUnderflow, aBad}), 32'd0);
        checkVal("reset B in_ready", 32'(bInReady), 32'd7);

        // ForIn replay on A channel 0
        aOutReady = 2'b01;
        extPush(0, 0, 12'd33);
        extPush(0, 0, 12'd22);
        extPush(0, 0, 12'd11);
        maxLat = 0;
        for (int v = 1; v <= 3; v++) begin
            cpuOp(0, OP_OUT, 0, 12'(v), r, lat);
            if (lat > maxLat) maxLat = lat;
        end
        s = '1;
        for (int it = 0; it < 5; it++) begin
            cpuOp(0, OP_INSIZE, 0, '0, s, lat);
            if (lat > maxLat) maxLat = lat;
            if (s == '0) break;
            cpuOp(0, OP_OUT, 0, s, r, lat);
            cpuOp(0, OP_IN, 0, '0, r, lat);
            if (lat > maxLat) maxLat = lat;
            cpuOp(0, OP_OUT, 0, r, got, lat);
        end
        checkVal("forin last inSize", 32'(s), 32'd0);
        checkVal("forin op latency", 32'(maxLat), 32'd1);
        repeat (3) tick();
        checkVal("forin out count", 32'(aOutQ.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            got = (i < aOutQ.size()) ? aOutQ[i] : '1;
            checkVal("forin out word", 32'(got), 32'(forInExp[i]));
        end
        aOutReady = '0;

        // Blocking in on empty A channel 1
        aOp = OP_IN; aChan = 1'b1;
        doneCnt = 0;
        repeat (5) begin tick(); if (aDone) doneCnt++; end
        checkVal("blocked in early done", 32'(doneCnt), 32'd0);
        aInValid[1] = 1'b1; aInData[W +: W] = 12'd7;
        tick();
        aInValid[1] = 1'b0;
        checkVal("blocked in done at push edge", 32'(aDone), 32'd0);
        tick();
        checkVal("blocked in done", 32'(aDone), 32'd1);
        checkVal("blocked in rdata", 32'(aRdata), 32'd7);
        aOp = OP_NONE;
        tick();
        checkVal("blocked in underflow", 32'(aUnderflow), 32'd0);

        // Full input FIFO with simultaneous CPU pop and producer push
        for (int i = 0; i < 8; i++) extPush(0, 0, 12'(100 + i));
        checkVal("full in_ready", 32'(aInReady[0]), 32'd0);
        aInValid[0] = 1'b1; aInData[0 +: W] = 12'd108;
        cpuOp(0, OP_IN, 0, '0, r, lat);
        aInValid[0] = 1'b0;
        checkVal("full pop rdata", 32'(r), 32'd100);
        checkVal("full refill in_ready", 32'(aInReady[0]), 32'd0);
        cpuOp(0, OP_INSIZE, 0, '0, r, lat);
        checkVal("full inSize", 32'(r), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cpuOp(0, OP_IN, 0, '0, r, lat);
            checkVal("full drain order", 32'(r), 32'(101 + i));
        end

        // Reset while an out is blocked on a full output FIFO
        for (int i = 0; i < 8; i++) cpuOp(0, OP_OUT, 0, 12'(200 + i), r, lat);
        aOp = OP_OUT; aChan = 1'b0; aWdata = 12'd999;
        doneCnt = 0;
        repeat (3) begin tick(); if (aDone) doneCnt++; end
        reset = 1'b1;
        tick();
        if (aDone) doneCnt++;
        reset = 1'b0;
        aOp = OP_NONE;
        repeat (2) begin tick(); if (aDone) doneCnt++; end
        checkVal("reset mid-wait done", 32'(doneCnt), 32'd0);
        checkVal("reset mid-wait out_valid", 32'(aOutValid), 32'd0);
        checkVal("reset mid-wait in_ready", 32'(aInReady), 32'd3);
        checkVal("reset mid-wait flags", 32'({aOverflow, aUnderflow, aBad}), 32'd0);
        cpuOp(0, OP_INSIZE, 0, '0, r, lat);
        checkVal("reset mid-wait inSize", 32'(r), 32'd0);

        // Non-blocking overflow on B channel 0
        for (int v = 1; v <= 6; v++) cpuOp(1, OP_OUT, 0, 12'(v), r, lat);
        checkVal("nb overflow", 32'(bOverflow), 32'd1);
        bOutReady[0] = 1'b1;
        repeat (6) tick();
        bOutReady[0] = 1'b0;
        checkVal("nb drain count", 32'(bOutQ0.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < bOutQ0.size()) ? bOutQ0[i] : '1;
            checkVal("nb drain order", 32'(got), 32'(3 + i));
        end
        cpuOp(1, OP_IN, 0, '0, r, lat);
        checkVal("nb in empty rdata", 32'(r), 32'd0);
        checkVal("nb in empty latency", 32'(lat), 32'd1);
        checkVal("nb underflow", 32'(bUnderflow), 32'd1);

        // Full output FIFO, consumer pop and CPU push in the same cycle
        for (int v = 10; v <= 13; v++) cpuOp(1, OP_OUT, 1, 12'(v), r, lat);
        bOutReady[1] = 1'b1;
        cpuOp(1, OP_OUT, 1, 12'd14, r, lat);
        repeat (6) tick();
        bOutReady[1] = 1'b0;
        checkVal("simul pop overflow", 32'(bOverflow[1]), 32'd0);
        checkVal("simul pop count", 32'(bOutQ1.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            got = (i < bOutQ1.size()) ? bOutQ1[i] : '1;
            checkVal("simul pop order", 32'(got), 32'(10 + i));
        end

        // Out-of-range channel
        extPush(1, 2, 12'd9);
        checkVal("bad_chan before", 32'(bBad), 32'd0);
        cpuOp(1, OP_IN, 3, '0, r, lat);
        checkVal("bad_chan latency", 32'(lat), 32'd1);
        checkVal("bad_chan rdata", 32'(r), 32'd0);
        checkVal("bad_chan flag", 32'(bBad), 32'd1);
        checkVal("bad_chan underflow", 32'(bUnderflow), 32'd1);
        cpuOp(1, OP_INSIZE, 2, '0, r, lat);
        checkVal("bad_chan ch2 count", 32'(r), 32'd1);
        checkVal("bad_chan out_valid", 32'(bOutValid), 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
